// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends a latched bit pattern MSB-first, with optional
// repetitions and idle gaps. "repeat" is reserved in SystemVerilog, so that input is named repeats.
module serial_pattern_tx #(
  parameter int   WIDTH      = 8,
  parameter int   CNT_W      = 4,
  parameter int   GAP_W      = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH-1:0]       pattern,
  input  logic [$clog2(WIDTH):0] len,
  input  logic [CNT_W-1:0]       repeats,
  input  logic [GAP_W-1:0]       gap,
  output logic                   out,
  output logic                   valid,
  output logic                   busy,
  output logic                   done
);

  localparam int LW = $clog2(WIDTH) + 1;
  localparam int IW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [LW-1:0]    WIDTH_L = LW'(WIDTH);
  localparam logic [LW-1:0]    ONE_L   = LW'(1);
  localparam logic [IW-1:0]    IDX_Z   = {IW{1'b0}};
  localparam logic [CNT_W-1:0] REP_Z   = {CNT_W{1'b0}};
  localparam logic [GAP_W-1:0] GAP_Z   = {GAP_W{1'b0}};

  // Zero or oversize lengths fall back to the full pattern width.
  function automatic logic [LW-1:0] norm_len(input logic [LW-1:0] l);
    if ((l == {LW{1'b0}}) || (l > WIDTH_L)) begin
      norm_len = WIDTH_L;
    end else begin
      norm_len = l;
    end
  endfunction

  logic [1:0]       state_r,   state_s;
  logic [WIDTH-1:0] pat_r,     pat_s;
  logic [LW-1:0]    len_r,     len_s;
  logic [IW-1:0]    idx_r,     idx_s;
  logic [CNT_W-1:0] rep_r,     rep_s;
  logic [GAP_W-1:0] gap_r,     gap_s;
  logic [GAP_W-1:0] gap_cnt_r, gap_cnt_s;
  logic [LW-1:0]    len_in_s;
  logic             done_s;
  logic             out_s;

  // Next-state, counter and latch logic.
  always_comb begin
    state_s   = state_r;
    pat_s     = pat_r;
    len_s     = len_r;
    idx_s     = idx_r;
    rep_s     = rep_r;
    gap_s     = gap_r;
    gap_cnt_s = gap_cnt_r;
    done_s    = 1'b0;
    len_in_s  = norm_len(len);

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          pat_s     = pattern;
          len_s     = len_in_s;
          rep_s     = repeats;
          gap_s     = gap;
          gap_cnt_s = GAP_Z;
          idx_s     = IW'(len_in_s - ONE_L);
          state_s   = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (idx_r != IDX_Z) begin
          idx_s = idx_r - IW'(1);
        end else if (rep_r != REP_Z) begin
          rep_s = rep_r - CNT_W'(1);
          if (gap_r != GAP_Z) begin
            gap_cnt_s = gap_r - GAP_W'(1);
            state_s   = ST_GAP;
          end else begin
            idx_s = IW'(len_r - ONE_L);
          end
        end else begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end
      end
      ST_GAP: begin
        // gap_cnt holds the gap cycles still to come after the current one.
        if (gap_cnt_r == GAP_Z) begin
          idx_s   = IW'(len_r - ONE_L);
          state_s = ST_SHIFT;
        end else begin
          gap_cnt_s = gap_cnt_r - GAP_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (state_s == ST_SHIFT) begin
      out_s = pat_s[idx_s];
    end else begin
      out_s = IDLE_LEVEL;
    end
  end

  // State, latched transfer parameters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      pat_r     <= {WIDTH{1'b0}};
      len_r     <= {LW{1'b0}};
      idx_r     <= IDX_Z;
      rep_r     <= REP_Z;
      gap_r     <= GAP_Z;
      gap_cnt_r <= GAP_Z;
      out       <= IDLE_LEVEL;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_s;
      pat_r     <= pat_s;
      len_r     <= len_s;
      idx_r     <= idx_s;
      rep_r     <= rep_s;
      gap_r     <= gap_s;
      gap_cnt_r <= gap_cnt_s;
      out       <= out_s;
      valid     <= (state_s == ST_SHIFT);
      busy      <= (state_s != ST_IDLE);
      done      <= done_s;
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: expected per-cycle {out,valid,busy,done}
// tuples are queued when a transfer is requested and compared after each clock edge.
module tb_serial_pattern_tx;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int GAP_W = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic [WIDTH-1:0]       pattern;
  logic [$clog2(WIDTH):0] len;
  logic [CNT_W-1:0]       repeats;
  logic [GAP_W-1:0]       gap;
  logic                   out, valid, busy, done;

  logic [3:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  serial_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP_W(GAP_W), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
    .repeats(repeats), .gap(gap), .out(out), .valid(valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(4'b0000);
  endtask

  // Expected stream of one transfer, starting with the cycle after the start edge.
  task automatic push_transfer(input logic [7:0] p, input int l, input int r, input int g);
    int eff;
    eff = (l == 0 || l > WIDTH) ? WIDTH : l;
    for (int rep = 0; rep <= r; rep++) begin
      for (int i = eff - 1; i >= 0; i--) exp_q.push_back({p[i], 1'b1, 1'b1, 1'b0});
      if (rep < r) begin
        for (int k = 0; k < g; k++) exp_q.push_back(4'b0010);
      end
    end
    exp_q.push_back(4'b0001);
  endtask

  task automatic tick(input string tag);
    logic [3:0] obs;
    logic [3:0] expv;
    @(posedge clk);
    #1;
    obs = {out, valid, busy, done};
    if (exp_q.size() > 0) expv = exp_q.pop_front();
    else expv = 4'b0000;
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: out/valid/busy/done observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) tick(tag);
  endtask

  task automatic launch(input logic [7:0] p, input int l, input int r, input int g, input string tag);
    pattern = p;
    len     = ($clog2(WIDTH) + 1)'(l);
    repeats = CNT_W'(r);
    gap     = GAP_W'(g);
    start   = 1'b1;
    push_transfer(p, l, r, g);
    tick(tag);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pattern = '0; len = '0; repeats = '0; gap = '0;

    push_idle(2);
    drain("reset");
    reset = 1'b0;
    push_idle(2);
    drain("post_reset_idle");

    // 3-bit pattern 101, single send.
    launch(8'h05, 3, 0, 0, "len3");
    drain("len3");
    push_idle(2);
    drain("len3_idle");

    // len=0 is the full width.
    launch(8'hA5, 0, 0, 0, "len0");
    drain("len0");

    // Oversize length is also the full width.
    launch(8'h3C, 12, 0, 0, "len12");
    drain("len12");
    push_idle(1);
    drain("len12_idle");

    // Three sends with two-cycle gaps.
    launch(8'h05, 3, 2, 2, "rep2_gap2");
    drain("rep2_gap2");
    push_idle(1);
    drain("rep2_gap2_idle");

    // Back-to-back repetition; mid-transfer input changes must be ignored.
    launch(8'h05, 3, 1, 0, "b2b");
    tick("b2b");
    pattern = 8'hFF; len = 4'd5; repeats = 4'd7; gap = 4'd3; start = 1'b1;
    tick("b2b_midstart");
    start = 1'b0;
    drain("b2b");
    push_idle(2);
    drain("b2b_idle");

    // Reset during the second bit of a 4-bit send.
    pattern = 8'h0B; len = 4'd4; repeats = 4'd0; gap = 4'd0; start = 1'b1;
    exp_q.push_back(4'b1110);
    exp_q.push_back(4'b0110);
    exp_q.push_back(4'b0000);
    tick("abort_bit1");
    start = 1'b0;
    tick("abort_bit2");
    reset = 1'b1;
    tick("abort_reset");
    reset = 1'b0;
    push_idle(3);
    drain("abort_no_done");
    launch(8'h0B, 4, 0, 0, "after_abort");
    drain("after_abort");

    // Reset and start together: reset wins.
    reset = 1'b1; start = 1'b1; pattern = 8'hFF; len = 4'd8;
    push_idle(1);
    tick("reset_start");
    reset = 1'b0; start = 1'b0;
    push_idle(2);
    drain("reset_start_idle");

    // len=1 with maximum repeat count and one-cycle gaps.
    launch(8'h01, 1, 15, 1, "len1_maxrep");
    drain("len1_maxrep");
    push_idle(1);
    drain("len1_maxrep_idle");

    // start held high: transfers chain through the done cycle.
    pattern = 8'h02; len = 4'd2; repeats = 4'd0; gap = 4'd0; start = 1'b1;
    push_transfer(8'h02, 2, 0, 0);
    push_transfer(8'h02, 2, 0, 0);
    push_transfer(8'h02, 2, 0, 0);
    for (int i = 0; i < 9; i++) tick("chain");
    start = 1'b0;
    push_idle(3);
    drain("chain_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
